// File: rtl/aes_sbox_lane_arbiter.sv
// Purpose: shares one 32-bit S-box lane between a 128-bit state job (4 column passes) and a 32-bit SubWord job.
// Latency: state job 5 cycles req-sample to st_ack, key-schedule job 2 cycles req-sample to ks_ack.
// Backpressure: requests are level-held until ack; a second requester waits in IDLE, ties alternate via last_st.
module aes_sbox_lane_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req,
   input  logic [127:0] st_data,
   input  logic         st_dec,
   output logic         st_ack,
   output logic [127:0] st_result,
   input  logic         ks_req,
   input  logic [31:0]  ks_word,
   output logic         ks_ack,
   output logic [31:0]  ks_result,
   output logic [31:0]  sb_i,
   output logic         sb_dec,
   input  logic [31:0]  sb_o,
   output logic         busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ST     = 3'd1,
      S_KS     = 3'd2,
      S_ACK_ST = 3'd3,
      S_ACK_KS = 3'd4
   } state_t;

   state_t     state;
   logic [1:0] col;
   logic       last_st;

   // Lane input is only data-dependent while a job is actually using it.
   always_comb begin
      sb_i   = '0;
      sb_dec = 1'b0;
      case (state)
         S_ST: begin
            sb_i   = st_data[{col, 5'b00000} +: 32];
            sb_dec = st_dec;
         end
         S_KS: begin
            // key expansion only ever uses the forward S-box
            sb_i   = ks_word;
            sb_dec = 1'b0;
         end
         default: begin
            sb_i   = '0;
            sb_dec = 1'b0;
         end
      endcase
   end

   assign busy = (state != S_IDLE);

   // Sequencer: arbitration in IDLE, column walk in ST, single pass in KS, one-cycle acks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         col       <= 2'd0;
         last_st   <= 1'b1;
         st_ack    <= 1'b0;
         ks_ack    <= 1'b0;
         st_result <= '0;
         ks_result <= '0;
      end else begin
         st_ack <= 1'b0;
         ks_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               // on a tie the side that did not win last time goes first
               if (st_req && (!ks_req || !last_st)) begin
                  col   <= 2'd0;
                  state <= S_ST;
               end else if (ks_req) begin
                  state <= S_KS;
               end
            end
            S_ST: begin
               st_result[{col, 5'b00000} +: 32] <= sb_o;
               col <= col + 2'd1;
               if (col == 2'd3) begin
                  st_ack <= 1'b1;
                  state  <= S_ACK_ST;
               end
            end
            S_KS: begin
               ks_result <= sb_o;
               ks_ack    <= 1'b1;
               state     <= S_ACK_KS;
            end
            S_ACK_ST: begin
               last_st <= 1'b1;
               state   <= S_IDLE;
            end
            S_ACK_KS: begin
               last_st <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_sbox_lane_arbiter.sv
// Purpose: directed bench for aes_sbox_lane_arbiter with a behavioural AES S-box lane.
// Latency: checks state-job ack at cycle 5 and key-schedule ack at cycle 2 after the req sample.
// Backpressure: exercises ties, alternation, a request arriving mid-job, and reset mid-job.
module tb_aes_sbox_lane_arbiter;

   logic         clk;
   logic         rst;
   logic         st_req;
   logic [127:0] st_data;
   logic         st_dec;
   logic         st_ack;
   logic [127:0] st_result;
   logic         ks_req;
   logic [31:0]  ks_word;
   logic         ks_ack;
   logic [31:0]  ks_result;
   logic [31:0]  sb_i;
   logic         sb_dec;
   logic [31:0]  sb_o;
   logic         busy;

   int checks = 0;
   int errors = 0;

   aes_sbox_lane_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .st_req    (st_req),
      .st_data   (st_data),
      .st_dec    (st_dec),
      .st_ack    (st_ack),
      .st_result (st_result),
      .ks_req    (ks_req),
      .ks_word   (ks_word),
      .ks_ack    (ks_ack),
      .ks_result (ks_result),
      .sb_i      (sb_i),
      .sb_dec    (sb_dec),
      .sb_o      (sb_o),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // multiplicative inverse as a^254 (maps 0 to 0)
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x, input logic dec);
      logic [7:0] b;
      logic [7:0] t;
      if (!dec) begin
         b = ginv(x);
         return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
      t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return ginv(t);
   endfunction

   // combinational lane: four byte S-boxes, no pipeline stage
   always_comb begin
      sb_o = {sbox(sb_i[31:24], sb_dec), sbox(sb_i[23:16], sb_dec),
              sbox(sb_i[15:8], sb_dec),  sbox(sb_i[7:0], sb_dec)};
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full state job from the req-sample cycle through the IDLE cycle after ack.
   task automatic run_st(input string tag, input logic [127:0] data, input logic dec,
                         input logic [127:0] exp);
      st_data = data;
      st_dec  = dec;
      st_req  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick;
         chk({tag, " sb_i"},   sb_i,   data[32*c +: 32]);
         chk({tag, " sb_dec"}, sb_dec, dec);
         chk({tag, " busy"},   busy,   1'b1);
         chk({tag, " early ack"}, st_ack, 1'b0);
      end
      tick;
      chk({tag, " st_ack"}, st_ack, 1'b1);
      chk({tag, " result"}, st_result, exp);
      chk({tag, " ack lane idle"}, sb_i, 32'h0);
      st_req = 1'b0;
      tick;
      chk({tag, " ack pulse"}, st_ack, 1'b0);
      chk({tag, " idle busy"}, busy, 1'b0);
      chk({tag, " held"}, st_result, exp);
   endtask

   task automatic run_ks(input string tag, input logic [31:0] word, input logic [31:0] exp);
      ks_word = word;
      ks_req  = 1'b1;
      tick;
      chk({tag, " sb_i"},   sb_i,   word);
      chk({tag, " sb_dec"}, sb_dec, 1'b0);
      chk({tag, " busy"},   busy,   1'b1);
      tick;
      chk({tag, " ks_ack"}, ks_ack, 1'b1);
      chk({tag, " result"}, ks_result, exp);
      ks_req = 1'b0;
      tick;
      chk({tag, " ack pulse"}, ks_ack, 1'b0);
      chk({tag, " idle busy"}, busy, 1'b0);
   endtask

   localparam logic [127:0] COLS     = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] COLS_SB  = 128'h76abd7fe_2b670130_c56f6bf2_7b777c63;
   localparam logic [127:0] ALL_63   = {16{8'h63}};
   localparam logic [127:0] ALL_53   = {16{8'h53}};
   localparam logic [127:0] ALL_ED   = {16{8'hed}};

   initial begin
      int ack_n;
      int ack_cyc [8];
      logic ack_ks [8];

      rst     = 1'b1;
      st_req  = 1'b0;
      st_data = '0;
      st_dec  = 1'b0;
      ks_req  = 1'b0;
      ks_word = '0;
      tick;
      tick;
      chk("reset st_ack",    st_ack,    1'b0);
      chk("reset ks_ack",    ks_ack,    1'b0);
      chk("reset st_result", st_result, 128'h0);
      chk("reset ks_result", ks_result, 32'h0);
      chk("reset sb_i",      sb_i,      32'h0);
      chk("reset sb_dec",    sb_dec,    1'b0);
      chk("reset busy",      busy,      1'b0);
      rst = 1'b0;

      // basic state jobs: forward, inverse, and distinct columns
      run_st("st zero", 128'h0, 1'b0, ALL_63);
      run_st("st inv63", ALL_63, 1'b1, 128'h0);
      run_st("st fwd53", ALL_53, 1'b0, ALL_ED);
      run_st("st cols", COLS, 1'b0, COLS_SB);

      // key-schedule jobs ignore st_dec and leave st_result alone
      run_ks("ks fwd", 32'hcf4f3c09, 32'h8a84eb01);
      st_dec = 1'b1;
      run_ks("ks dec held", 32'hcf4f3c09, 32'h8a84eb01);
      st_dec = 1'b0;
      chk("st_result after ks", st_result, COLS_SB);

      // tie right after reset: KS first, then strict alternation
      rst = 1'b1;
      tick;
      rst = 1'b0;
      st_data = COLS;
      ks_word = 32'h00010203;
      st_req  = 1'b1;
      ks_req  = 1'b1;
      ack_n   = 0;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         tick;
         if (cyc == 1) chk("tie first grant ks", sb_i, 32'h00010203);
         if (cyc == 4) chk("tie second grant st", sb_i, 32'h03020100);
         if ((st_ack || ks_ack) && ack_n < 8) begin
            ack_cyc[ack_n] = cyc;
            ack_ks[ack_n]  = ks_ack;
            ack_n++;
         end
      end
      st_req = 1'b0;
      ks_req = 1'b0;
      chk("tie job count", ack_n, 8);
      for (int j = 0; j < 8; j++) begin
         if (j < ack_n) begin
            chk($sformatf("tie job%0d cycle", j), ack_cyc[j], 9 * (j / 2) + ((j % 2) != 0 ? 8 : 2));
            chk($sformatf("tie job%0d kind", j), ack_ks[j], ((j % 2) == 0));
         end
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      tick;

      // ks request arriving mid state job waits for the state job to finish
      st_data = ALL_53;
      st_req  = 1'b1;
      tick;
      tick;
      ks_word = 32'hcf4f3c09;
      ks_req  = 1'b1;
      tick;
      tick;
      chk("mid ks col3 sb_i", sb_i, 32'h53535353);
      chk("mid ks no ks_ack", ks_ack, 1'b0);
      tick;
      chk("mid ks st_ack", st_ack, 1'b1);
      chk("mid ks st_result", st_result, ALL_ED);
      st_req = 1'b0;
      tick;
      chk("mid ks idle", busy, 1'b0);
      tick;
      chk("mid ks granted sb_i", sb_i, 32'hcf4f3c09);
      tick;
      chk("mid ks ks_ack", ks_ack, 1'b1);
      chk("mid ks ks_result", ks_result, 32'h8a84eb01);
      ks_req = 1'b0;
      tick;

      // reset during cycle 3 of a state job aborts it and clears results
      st_data = COLS;
      st_req  = 1'b1;
      tick;
      tick;
      tick;
      rst    = 1'b1;
      st_req = 1'b0;
      tick;
      rst = 1'b0;
      chk("abort busy",      busy,      1'b0);
      chk("abort st_ack",    st_ack,    1'b0);
      chk("abort st_result", st_result, 128'h0);
      chk("abort ks_result", ks_result, 32'h0);
      tick;
      tick;
      chk("abort no late ack", st_ack, 1'b0);
      chk("abort still idle",  busy,   1'b0);
      run_st("st after abort", COLS, 1'b0, COLS_SB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
